// File: rtl/hpi_bus_demux_pkg.sv
// Shared definitions for the HPI register-bus demultiplexer.
package hpi_bus_demux_pkg;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } hpi_state_e;

    // Default slave ack timeout, in clock cycles.
    localparam int unsigned HPI_TIMEOUT_CYC_DEF = 256;

    // Default read data returned on timeout or decode error.
    localparam logic [31:0] HPI_ERR_DATA_DEF = 32'hDEAD_BEEF;

    // Width of the saturating error counter.
    localparam int unsigned HPI_CNT_W = 16;

endpackage

// File: rtl/hpi_bus_demux_to_cnt.sv
// Slave ack timeout counter plus the saturating error counter and sticky flag.
module hpi_to_cnt
    import hpi_bus_demux_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = HPI_TIMEOUT_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tmo_load,
    input  logic                 tmo_run,
    input  logic                 err_evt,
    input  logic                 to_clr,
    output logic                 tmo_hit,
    output logic [HPI_CNT_W-1:0] to_cnt,
    output logic                 to_err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);

    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [HPI_CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic                 to_err_q, to_err_d;
    logic [HPI_CNT_W-1:0] cnt_base;

    // Last waiting cycle: the slave still gets this cycle to ack.
    assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

    // Timeout counter restarts in ISSUE, advances in WAIT; error count saturates
    // and a coincident clear still records the new error.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (tmo_load) begin
            tmo_cnt_d = '0;
        end else if (tmo_run) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end

        cnt_base = to_clr ? '0 : to_cnt_q;
        to_cnt_d = cnt_base;
        to_err_d = to_clr ? 1'b0 : to_err_q;
        if (err_evt) begin
            to_err_d = 1'b1;
            if (cnt_base != '1) begin
                to_cnt_d = cnt_base + 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            to_cnt_q  <= '0;
            to_err_q  <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            to_cnt_q  <= to_cnt_d;
            to_err_q  <= to_err_d;
        end
    end

    assign to_cnt = to_cnt_q;
    assign to_err = to_err_q;

endmodule

// File: rtl/hpi_bus_demux.sv
// Decodes single-beat CPU bus requests onto NUM_SLV register slaves, waits for
// the selected slave's ack (or a timeout) and returns a one-cycle completion.
module hpi_bus_demux
    import hpi_bus_demux_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           NUM_SLV     = 4,
    parameter int unsigned           SEL_LSB     = 14,
    parameter int unsigned           TIMEOUT_CYC = HPI_TIMEOUT_CYC_DEF,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA    = DATA_WIDTH'(HPI_ERR_DATA_DEF)
) (
    input  logic                          clks,
    input  logic                          reset,
    input  logic                          cpu_wr,
    input  logic                          cpu_rd,
    input  logic [ADDR_WIDTH-1:0]         cpu_addr,
    input  logic [DATA_WIDTH-1:0]         cpu_data_in,
    output logic [DATA_WIDTH-1:0]         cpu_data_out,
    output logic                          cpu_ack,
    output logic                          cpu_busy,
    output logic [NUM_SLV-1:0]            slv_wr,
    output logic [NUM_SLV-1:0]            slv_rd,
    output logic [SEL_LSB-3:0]            slv_addr,
    output logic [DATA_WIDTH-1:0]         slv_wdata,
    input  logic [NUM_SLV-1:0]            slv_ack,
    input  logic [NUM_SLV*DATA_WIDTH-1:0] slv_rdata,
    input  logic                          to_clr,
    output logic [HPI_CNT_W-1:0]          to_cnt,
    output logic                          to_err
);

    localparam int unsigned SEL_W  = $clog2(NUM_SLV);
    localparam int unsigned HI_LSB = SEL_LSB + SEL_W;

    hpi_state_e            state_q, state_d;
    logic                  is_wr_q, is_wr_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [SEL_LSB-3:0]    slv_addr_q, slv_addr_d;
    logic [DATA_WIDTH-1:0] slv_wdata_q, slv_wdata_d;
    logic [NUM_SLV-1:0]    slv_wr_q, slv_wr_d;
    logic [NUM_SLV-1:0]    slv_rd_q, slv_rd_d;
    logic                  cpu_ack_q, cpu_ack_d;
    logic                  cpu_busy_q, cpu_busy_d;
    logic [DATA_WIDTH-1:0] cpu_data_q, cpu_data_d;

    logic [SEL_W-1:0]      cpu_sel;
    logic [NUM_SLV-1:0]    cpu_sel_oh;
    logic                  dec_err;
    logic                  sel_ack;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  tmo_load, tmo_run, tmo_hit, err_evt;

    // Region select and decode check on the incoming address; any bit above the
    // select field set means the address maps to no slave.
    assign cpu_sel    = cpu_addr[SEL_LSB +: SEL_W];
    assign cpu_sel_oh = NUM_SLV'(1) << cpu_sel;
    assign dec_err    = |(cpu_addr >> HI_LSB);

    // Only the slave that was strobed can complete the transaction.
    assign sel_ack   = slv_ack[sel_q];
    assign sel_rdata = slv_rdata[sel_q*DATA_WIDTH +: DATA_WIDTH];

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        sel_d       = sel_q;
        slv_addr_d  = slv_addr_q;
        slv_wdata_d = slv_wdata_q;
        slv_wr_d    = '0;
        slv_rd_d    = '0;
        cpu_ack_d   = 1'b0;
        cpu_busy_d  = cpu_busy_q;
        cpu_data_d  = cpu_data_q;
        tmo_load    = 1'b0;
        tmo_run     = 1'b0;
        err_evt     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cpu_wr || cpu_rd) begin
                    // Write wins when both pulse together.
                    is_wr_d     = cpu_wr;
                    sel_d       = cpu_sel;
                    slv_addr_d  = cpu_addr[SEL_LSB-1:2];
                    slv_wdata_d = cpu_data_in;
                    cpu_busy_d  = 1'b1;
                    if (dec_err) begin
                        state_d   = ST_DONE;
                        cpu_ack_d = 1'b1;
                        err_evt   = 1'b1;
                        if (!cpu_wr) begin
                            cpu_data_d = ERR_DATA;
                        end
                    end else begin
                        state_d = ST_ISSUE;
                        if (cpu_wr) begin
                            slv_wr_d = cpu_sel_oh;
                        end else begin
                            slv_rd_d = cpu_sel_oh;
                        end
                    end
                end
            end
            ST_ISSUE, ST_WAIT: begin
                tmo_load = (state_q == ST_ISSUE);
                tmo_run  = (state_q == ST_WAIT);
                if (sel_ack) begin
                    state_d   = ST_DONE;
                    cpu_ack_d = 1'b1;
                    if (!is_wr_q) begin
                        cpu_data_d = sel_rdata;
                    end
                end else if (state_q == ST_WAIT && tmo_hit) begin
                    state_d   = ST_DONE;
                    cpu_ack_d = 1'b1;
                    err_evt   = 1'b1;
                    if (!is_wr_q) begin
                        cpu_data_d = ERR_DATA;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                cpu_busy_d = 1'b0;
            end
            default: begin
                state_d    = ST_IDLE;
                cpu_busy_d = 1'b0;
            end
        endcase
    end

    // Sequencer and output registers.
    always_ff @(posedge clks or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            is_wr_q     <= 1'b0;
            sel_q       <= '0;
            slv_addr_q  <= '0;
            slv_wdata_q <= '0;
            slv_wr_q    <= '0;
            slv_rd_q    <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_busy_q  <= 1'b0;
            cpu_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            sel_q       <= sel_d;
            slv_addr_q  <= slv_addr_d;
            slv_wdata_q <= slv_wdata_d;
            slv_wr_q    <= slv_wr_d;
            slv_rd_q    <= slv_rd_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_busy_q  <= cpu_busy_d;
            cpu_data_q  <= cpu_data_d;
        end
    end

    hpi_to_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_to_cnt (
        .clk      (clks),
        .rst      (reset),
        .tmo_load (tmo_load),
        .tmo_run  (tmo_run),
        .err_evt  (err_evt),
        .to_clr   (to_clr),
        .tmo_hit  (tmo_hit),
        .to_cnt   (to_cnt),
        .to_err   (to_err)
    );

    assign cpu_data_out = cpu_data_q;
    assign cpu_ack      = cpu_ack_q;
    assign cpu_busy     = cpu_busy_q;
    assign slv_wr       = slv_wr_q;
    assign slv_rd       = slv_rd_q;
    assign slv_addr     = slv_addr_q;
    assign slv_wdata    = slv_wdata_q;

endmodule
